// File: rtl/shift_capture.sv
// Dual serial-to-parallel capture: shifts A/B bit streams LSB first into WIDTH-bit
// words and presents them with a Valid/Ack handshake and a sticky lost-Start flag.
module shift_capture #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Shift_En,
  input  logic             A_In,
  input  logic             B_In,
  input  logic             Ack,
  output logic [WIDTH-1:0] A_Cap,
  output logic [WIDTH-1:0] B_Cap,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLD} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sa, r_sb;

  logic             w_load, w_shift, w_done, w_lost, w_ack;
  logic [CW-1:0]    w_cnt_base;
  logic [WIDTH-1:0] w_sa_base, w_sb_base, w_sa_nxt, w_sb_nxt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_lost  = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_load  = 1'b1;
          w_shift = Shift_En;
          w_next  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_shift = Shift_En;
        w_lost  = Start;
      end
      S_HOLD: begin
        if (Ack) begin
          w_ack = 1'b1;
          if (Start) begin
            w_load = 1'b1;
            w_next = S_CAPTURE;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_lost = Start;
        end
      end
      default: w_next = S_IDLE;
    endcase

    // A fresh start shifts on top of a cleared word, so a same-cycle bit lands as bit 0.
    w_cnt_base = w_load ? '0 : r_cnt;
    w_sa_base  = w_load ? '0 : r_sa;
    w_sb_base  = w_load ? '0 : r_sb;
    w_sa_nxt   = (w_sa_base >> 1) | (WIDTH'(A_In) << (WIDTH - 1));
    w_sb_nxt   = (w_sb_base >> 1) | (WIDTH'(B_In) << (WIDTH - 1));
    w_done     = w_shift && (w_cnt_base == CW'(WIDTH - 1));
    if (w_done) w_next = S_HOLD;
  end

  assign Busy = (r_state != S_IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      A_Cap   <= '0;
      B_Cap   <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (w_load || w_shift) begin
        r_cnt <= w_shift ? w_cnt_base + CW'(1) : w_cnt_base;
        r_sa  <= w_shift ? w_sa_nxt : w_sa_base;
        r_sb  <= w_shift ? w_sb_nxt : w_sb_base;
      end
      if (w_done) begin
        A_Cap <= w_sa_nxt;
        B_Cap <= w_sb_nxt;
        Valid <= 1'b1;
      end else if (w_ack) begin
        Valid <= 1'b0;
      end
      if (w_lost) Overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_shift_capture.sv
// Directed and random checks of shift_capture against a bit-list reference model.
module tb_shift_capture;
  localparam int W = 8;

  logic         Clk = 1'b0, Reset = 1'b0;
  logic         Start = 0, Shift_En = 0, A_In = 0, B_In = 0, Ack = 0;
  logic [W-1:0] A_Cap, B_Cap;
  logic         Valid, Busy, Overrun;

  shift_capture #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Shift_En(Shift_En), .A_In(A_In),
    .B_In(B_In), .Ack(Ack), .A_Cap(A_Cap), .B_Cap(B_Cap), .Valid(Valid),
    .Busy(Busy), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_pass = 0;

  // Reference: collecting flag, holding flag, and bits gathered so far by index.
  bit           m_coll, m_hold, m_ovr;
  int           m_n;
  logic [W-1:0] m_a, m_b, m_acap, m_bcap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_acap"}, 32'(A_Cap), 32'(m_acap));
    chk({tag, "_bcap"}, 32'(B_Cap), 32'(m_bcap));
    chk({tag, "_valid"}, 32'(Valid), 32'(m_hold));
    chk({tag, "_busy"}, 32'(Busy), 32'(m_coll | m_hold));
    chk({tag, "_ovr"}, 32'(Overrun), 32'(m_ovr));
  endtask

  task automatic model_reset();
    m_coll = 0; m_hold = 0; m_ovr = 0; m_n = 0;
    m_a = '0; m_b = '0; m_acap = '0; m_bcap = '0;
  endtask

  task automatic begin_word();
    m_coll = 1; m_n = 0; m_a = '0; m_b = '0;
  endtask

  task automatic take_bit();
    m_a[m_n] = A_In;
    m_b[m_n] = B_In;
    m_n++;
    if (m_n == W) begin
      m_acap = m_a; m_bcap = m_b;
      m_coll = 0; m_hold = 1;
    end
  endtask

  task automatic model_clock();
    if (m_hold) begin
      if (Ack) begin
        m_hold = 0;
        if (Start) begin_word();
      end else if (Start) m_ovr = 1;
    end else if (m_coll) begin
      if (Start) m_ovr = 1;
      if (Shift_En) take_bit();
    end else if (Start) begin
      begin_word();
      if (Shift_En) take_bit();
    end
  endtask

  // Entered and left at a falling edge.
  task automatic step(input logic st, input logic sh, input logic a, input logic b,
                      input logic ak, input string tag);
    Start = st; Shift_En = sh; A_In = a; B_In = b; Ack = ak;
    @(posedge Clk);
    model_clock();
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] aw, input logic [W-1:0] bw,
                      input int gap_after, input int gapn, input int lost_at, input string tag);
    step(1, 0, 0, 0, 0, tag);
    for (int i = 0; i < W; i++) begin
      step(logic'(i == lost_at), 1, aw[i], bw[i], 0, tag);
      if (i == gap_after)
        for (int g = 0; g < gapn; g++)
          step(0, 0, logic'($urandom_range(1)), logic'($urandom_range(1)), 0, tag);
    end
  endtask

  initial begin
    model_reset();
    @(negedge Clk);
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b1;
    step(0, 1, 1, 1, 0, "idle_ignore");

    send(8'b0101_1010, 8'b0000_1111, -1, 0, -1, "basic");
    chk("basic_a", 32'(A_Cap), 32'h5A);
    chk("basic_b", 32'(B_Cap), 32'h0F);
    chk("basic_v", 32'(Valid), 32'd1);
    step(0, 1, 1, 1, 0, "hold_ignore");
    step(0, 0, 0, 0, 1, "basic_ack");
    chk("ack_v", 32'(Valid), 32'd0);
    chk("ack_busy", 32'(Busy), 32'd0);

    send(8'b0101_1010, 8'b0000_1111, 3, 3, -1, "gap");
    chk("gap_a", 32'(A_Cap), 32'h5A);
    chk("gap_b", 32'(B_Cap), 32'h0F);
    step(0, 0, 0, 0, 1, "gap_ack");

    step(1, 1, 1, 0, 0, "same");
    for (int i = 1; i < W; i++) step(0, 1, 0, 0, 0, "same");
    chk("same_a", 32'(A_Cap), 32'h01);
    chk("same_v", 32'(Valid), 32'd1);
    step(0, 0, 0, 0, 1, "same_ack");

    send(8'b0101_1010, 8'b0000_1111, -1, 0, 3, "lost");
    chk("lost_ovr", 32'(Overrun), 32'd1);
    chk("lost_a", 32'(A_Cap), 32'h5A);
    step(1, 0, 0, 0, 0, "lost_hold_start");
    step(0, 0, 0, 0, 1, "lost_ack");
    chk("lost_ovr_sticky", 32'(Overrun), 32'd1);

    do_reset("rst1");
    send(8'h00, 8'hAA, -1, 0, -1, "b2b_1");
    step(1, 0, 0, 0, 1, "b2b_go");
    chk("b2b_v", 32'(Valid), 32'd0);
    chk("b2b_busy", 32'(Busy), 32'd1);
    for (int i = 0; i < W; i++) step(0, 1, 1, 0, 0, "b2b_2");
    chk("b2b_a", 32'(A_Cap), 32'hFF);
    chk("b2b_v2", 32'(Valid), 32'd1);
    chk("b2b_ovr", 32'(Overrun), 32'd0);
    step(0, 0, 0, 0, 1, "b2b_ack");

    step(1, 0, 0, 0, 0, "mid");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0, "mid");
    do_reset("mid_rst");
    chk("mid_rst_a", 32'(A_Cap), 32'h0);
    for (int i = 0; i < W; i++) step(0, 1, 1, 1, 0, "mid_nostart");
    chk("mid_nostart_busy", 32'(Busy), 32'd0);
    send(8'h3C, 8'hC3, -1, 0, -1, "mid_after");
    chk("mid_after_a", 32'(A_Cap), 32'h3C);
    step(0, 0, 0, 0, 1, "mid_ack");

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(99) == 0) do_reset("rnd_rst");
      else step(logic'($urandom_range(99) < 15), logic'($urandom_range(99) < 60),
                logic'($urandom_range(1)), logic'($urandom_range(1)),
                logic'($urandom_range(99) < 30), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
